// File: rtl/pair_entry_fifo_pkg.sv
// Shared widths, field positions and record-building helpers for the pair entry FIFO.
// A pipeline record is {seq, valid_b, valid_a, field_b, field_a}; a FIFO entry is {host_null, host_in}.
package pair_entry_fifo_pkg;

    localparam int REC_W   = 227;
    localparam int ENTRY_W = 194;
    localparam int FIELD_W = 97;
    localparam int DATA_W  = 96;
    localparam int HOST_W  = 192;
    localparam int SEQ_W   = 31;

    localparam int FIELD_A_LSB = 0;
    localparam int FIELD_B_LSB = 97;
    localparam int VALID_A_BIT = 194;
    localparam int VALID_B_BIT = 195;
    localparam int SEQ_LSB     = 196;

    // Null flags sit above the two 96-bit halves inside a stored entry.
    localparam int NULL_A_BIT = 192;
    localparam int NULL_B_BIT = 193;

    localparam logic [FIELD_W-1:0] NULL_FIELD = 97'h1_0000_0000_0000_0000_0000_0000;

    typedef logic [REC_W-1:0]   record_t;
    typedef logic [ENTRY_W-1:0] entry_t;

    function automatic logic [FIELD_W-1:0] make_field(input logic [DATA_W-1:0] data,
                                                      input logic is_null);
        return is_null ? NULL_FIELD : {1'b0, data};
    endfunction

    function automatic record_t build_record(input entry_t entry, input logic [SEQ_W-1:0] seq);
        record_t rec;
        rec = '0;
        rec[FIELD_A_LSB +: FIELD_W] = make_field(entry[0 +: DATA_W], entry[NULL_A_BIT]);
        rec[FIELD_B_LSB +: FIELD_W] = make_field(entry[DATA_W +: DATA_W], entry[NULL_B_BIT]);
        rec[VALID_A_BIT]            = !entry[NULL_A_BIT];
        rec[VALID_B_BIT]            = !entry[NULL_B_BIT];
        rec[SEQ_LSB +: SEQ_W]       = seq;
        return rec;
    endfunction

endpackage

// File: rtl/pair_entry_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO: dout always presents the oldest entry while not empty.
// Push while full and pop while empty are ignored; reset flushes the contents.
module pe_sync_fifo
    import pair_entry_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // The extra pointer MSB separates a full ring from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/pair_entry_fifo.sv
// Frame-paced pair FIFO: accepts at most one host pair per 16-cycle frame and
// emits formatted, sequence-numbered records in the emission slots of each frame.
module pair_entry_fifo
    import pair_entry_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int SLOTS = 14
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [HOST_W-1:0]      host_in,
    input  logic [1:0]             host_null,
    input  logic                   write_ctrl,
    input  logic                   out_ready,
    output logic [REC_W-1:0]       out,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    // Counters 14 and 15 are reserved for the host write, whatever SLOTS says.
    localparam logic [4:0] SLOT_LIMIT = (SLOTS < 14) ? 5'(SLOTS) : 5'd14;

    logic [3:0]       counter;
    logic             host_prev;
    logic [SEQ_W-1:0] seq;
    logic             fifo_empty;
    entry_t           fifo_dout;
    logic             frame_edge;
    logic             write_req;
    logic             push;
    logic             drop;
    logic             pop;

    // A write is a rising edge of write_ctrl as seen only at frame boundaries.
    assign frame_edge = (counter == 4'd15);
    assign write_req  = frame_edge && write_ctrl && !host_prev;
    assign push       = write_req && !full;
    assign drop       = write_req && full;
    assign pop        = ({1'b0, counter} < SLOT_LIMIT) && !fifo_empty && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            counter   <= 4'd15;
            host_prev <= 1'b1;
            seq       <= '0;
            overflow  <= 1'b0;
            out       <= '0;
        end else begin
            counter <= counter + 4'd1;
            if (frame_edge) begin
                host_prev <= write_ctrl;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                seq <= seq + 1'b1;
                out <= build_record(fifo_dout, seq);
            end else begin
                out <= '0;
            end
        end
    end

    pe_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({host_null, host_in}),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (full),
        .count (count)
    );

endmodule

// File: doc/pair_entry_fifo.md
PAIR_ENTRY_FIFO -- requirements
Module: pair_entry_fifo

Interface
REQ-001 SHALL have parameters: DEPTH, default 16, FIFO entries (power of 2); SLOTS, default 14, emission slots per frame.
REQ-002 SHALL have ports: clk  in  1  clock; reset  in  1  reset (reset reset, synchronous, active-high; clock clk).
REQ-003 SHALL have ports: host_in  in  192  pair from host, A = [0+:96], B = [96+:96]; host_null  in  2  [0] A null, [1] B null; write_ctrl  in  1  host write strobe (level).
REQ-004 SHALL have ports: out_ready  in  1  pipeline accepts; out  out  227  pair record to pipeline; full  out  1; count  out  5  entries held; overflow  out  1  sticky dropped-write flag.

Function
REQ-005 SHALL keep a 4-bit frame counter, reset value 15, incrementing each cycle and wrapping 15->0.
REQ-006 SHALL register host_prev <= write_ctrl only in cycles where counter==15.
REQ-007 SHALL push on counter==15 && write_ctrl==1 && host_prev==0 && !full: at most one push per frame; holding write_ctrl high across frames yields one push only.
REQ-008 SHALL drop a push attempted while full and set overflow to 1 until reset.
REQ-009 SHALL store per entry {host_null, host_in} (194 bits).
REQ-010 SHALL pop when counter < SLOTS && !empty && out_ready; never pop in counters 14, 15.
REQ-011 SHALL register out one cycle after a pop; in every non-pop cycle out SHALL be 227'b0.
REQ-012 SHALL format out: [0+:97] = A field, [97+:97] = B field, [194] = valid A, [195] = valid B, [196+:31] = seq.
REQ-013 SHALL build a non-null field as {1'b0, 96-bit data} with valid 1; a null field SHALL be 97'h1_0000_0000_0000_0000_0000_0000 with valid 0.
REQ-014 SHALL emit a popped entry whose halves are both null, with both valid bits 0 and seq still consumed.
REQ-015 SHALL hold a 31-bit seq, reset 0, incremented by 1 per pop and wrapping 0x7FFFFFFF->0.
REQ-016 SHALL drive count as the registered occupancy (0..DEPTH); full = (count==DEPTH).
REQ-017 SHALL never see push and pop in the same cycle (disjoint counter windows); the FIFO need not handle simultaneous push and pop.
REQ-018 SHALL wrap FIFO read/write pointers modulo DEPTH, with one extra pointer bit distinguishing full from empty.
REQ-019 SHALL stall emission while out_ready==0: no pop, out=0, and seq unchanged.

Reset
REQ-020 SHALL, on reset, set counter=15, host_prev=1, seq=0, count=0, overflow=0, out=0, and flush the FIFO, aborting any pending emission.
REQ-021 SHALL accept no push on the first counter==15 after reset if write_ctrl stays high throughout reset.

Structure
REQ-022 SHALL take from the shared package: record widths (227, 194, 97, 96), the null-particle constant 97'h1_0000_0000_0000_0000_0000_0000, and the bit positions of valid A, valid B and seq.
REQ-023 SHALL use one sub-module pe_sync_fifo: synchronous FIFO, DEPTH x 194, with push, pop, dout, empty, full and count; all frame, format and host logic SHALL stay in pair_entry_fifo.

Verification
REQ-024 SHALL cover single write: after reset, raise write_ctrl at counter 15 with host_in A=96'h5, B=96'h7 and host_null=0 -> in the next frame out[0+:97]=97'h5, out[97+:97]=97'h7, bits 194/195=1, seq=0, exactly once.
REQ-025 SHALL cover a held strobe: write_ctrl high for 3 frames -> count=1, exactly one record out.
REQ-026 SHALL cover a null half: host_null=2'b10 -> out[97+:97]=null constant, bit195=0, bit194=1.
REQ-027 SHALL cover overflow: 17 toggled writes with out_ready=0 -> count=16, full=1, overflow=1; then out_ready=1 -> 16 records with seq 0..15 in write order, never in counters 15/0 output slots.
REQ-028 SHALL cover reset mid-frame: reset at counter 7 with count=3 -> next cycle out=0, count=0, seq=0, counter=15.
REQ-029 SHALL cover seq wrap: preload seq=0x7FFFFFFF by force, two pops -> seq fields 0x7FFFFFFF then 0.
